// File: rtl/huffman_enc_arbiter.sv
// Round-robin arbiter sharing one Huffman encoder between two byte streams.
// A tag pipeline matched to the encoder latency routes each result word back to its channel.
module huffman_enc_arbiter #(
    parameter int unsigned ENC_LAT = 1,
    parameter int unsigned BURST   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch0_valid,
    input  logic [7:0]  ch0_data,
    output logic        ch0_ready,
    input  logic        ch1_valid,
    input  logic [7:0]  ch1_data,
    output logic        ch1_ready,
    output logic        enc_enable,
    output logic [7:0]  enc_data_in,
    input  logic [15:0] enc_data_out,
    output logic        out_valid,
    output logic        out_ch,
    output logic [15:0] out_data,
    output logic        busy
);

    localparam int unsigned TAG_D     = ENC_LAT + 1;
    localparam logic [3:0]  BCNT_LAST = 4'(BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_oth_state;
    logic             r_rr_last;
    logic             w_rr_last_nxt;
    logic [3:0]       r_bcnt;
    logic [3:0]       w_bcnt_nxt;
    logic             w_gnt_ch;
    logic             w_own_valid;
    logic             w_oth_valid;
    logic             w_xfer;
    logic [7:0]       w_byte;
    logic [TAG_D-1:0] r_tag_v;
    logic [TAG_D-1:0] r_tag_ch;
    logic             r_enc_enable;
    logic [7:0]       r_enc_data_in;
    logic             r_out_valid;
    logic             r_out_ch;
    logic [15:0]      r_out_data;

    // View of the granted channel versus the other one
    assign w_gnt_ch    = (r_state == S_GNT1);
    assign w_own_valid = w_gnt_ch ? ch1_valid : ch0_valid;
    assign w_oth_valid = w_gnt_ch ? ch0_valid : ch1_valid;
    assign w_oth_state = w_gnt_ch ? S_GNT0 : S_GNT1;
    assign w_byte      = w_gnt_ch ? ch1_data : ch0_data;
    assign w_xfer      = (r_state != S_IDLE) && w_own_valid;

    always_comb begin
        w_state_nxt   = r_state;
        w_bcnt_nxt    = r_bcnt;
        w_rr_last_nxt = r_rr_last;
        case (r_state)
            S_IDLE: begin
                w_bcnt_nxt = '0;
                if (ch0_valid && ch1_valid) begin
                    w_state_nxt = r_rr_last ? S_GNT0 : S_GNT1;
                end else if (ch0_valid) begin
                    w_state_nxt = S_GNT0;
                end else if (ch1_valid) begin
                    w_state_nxt = S_GNT1;
                end
            end
            S_GNT0, S_GNT1: begin
                if (!w_own_valid) begin
                    w_bcnt_nxt  = '0;
                    w_state_nxt = w_oth_valid ? w_oth_state : S_IDLE;
                end else begin
                    w_rr_last_nxt = w_gnt_ch;
                    // Burst end only yields when the other side is waiting
                    if (r_bcnt == BCNT_LAST) begin
                        w_bcnt_nxt = '0;
                        if (w_oth_valid) begin
                            w_state_nxt = w_oth_state;
                        end
                    end else begin
                        w_bcnt_nxt = r_bcnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_bcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_rr_last <= 1'b1;
            r_bcnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_bcnt    <= w_bcnt_nxt;
        end
    end

    // Encoder drive, tag pipeline and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_enc_enable  <= 1'b0;
            r_enc_data_in <= '0;
            r_tag_v       <= '0;
            r_tag_ch      <= '0;
            r_out_valid   <= 1'b0;
            r_out_ch      <= 1'b0;
            r_out_data    <= '0;
        end else begin
            r_enc_enable <= w_xfer;
            if (w_xfer) begin
                r_enc_data_in <= w_byte;
            end
            r_tag_v     <= {r_tag_v[TAG_D-2:0], w_xfer};
            r_tag_ch    <= {r_tag_ch[TAG_D-2:0], w_gnt_ch};
            r_out_valid <= r_tag_v[TAG_D-1];
            if (r_tag_v[TAG_D-1]) begin
                r_out_ch   <= r_tag_ch[TAG_D-1];
                r_out_data <= enc_data_out;
            end
        end
    end

    assign ch0_ready   = (r_state == S_GNT0);
    assign ch1_ready   = (r_state == S_GNT1);
    assign enc_enable  = r_enc_enable;
    assign enc_data_in = r_enc_data_in;
    assign out_valid   = r_out_valid;
    assign out_ch      = r_out_ch;
    assign out_data    = r_out_data;
    assign busy        = (r_state != S_IDLE) || (|r_tag_v);

endmodule

// File: tb/tb_huffman_enc_arbiter.sv
// Scoreboard bench: two arbiters (encoder latency 1 and 3) share the same stimulus and are
// checked against a transaction-level model of the round-robin grant rules.
module tb_huffman_enc_arbiter;

    localparam int unsigned BURST = 4;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    typedef struct packed {
        logic        ch;
        logic [15:0] word;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ch0_valid = 1'b0;
    logic [7:0]  ch0_data = '0;
    logic        ch1_valid = 1'b0;
    logic [7:0]  ch1_data = '0;

    logic        rdy0_a, rdy1_a, en_a, ov_a, och_a, busy_a;
    logic [7:0]  din_a;
    logic [15:0] dout_a, od_a;
    logic        rdy0_b, rdy1_b, en_b, ov_b, och_b, busy_b;
    logic [7:0]  din_b;
    logic [15:0] dout_b, od_b;

    always #5 clk = ~clk;

    huffman_enc_arbiter #(.ENC_LAT(LAT_A), .BURST(BURST)) u_dut_a (
        .clk(clk), .rst(rst),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(rdy0_a),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(rdy1_a),
        .enc_enable(en_a), .enc_data_in(din_a), .enc_data_out(dout_a),
        .out_valid(ov_a), .out_ch(och_a), .out_data(od_a), .busy(busy_a)
    );

    huffman_enc_arbiter #(.ENC_LAT(LAT_B), .BURST(BURST)) u_dut_b (
        .clk(clk), .rst(rst),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(rdy0_b),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(rdy1_b),
        .enc_enable(en_b), .enc_data_in(din_b), .enc_data_out(dout_b),
        .out_valid(ov_b), .out_ch(och_b), .out_data(od_b), .busy(busy_b)
    );

    function automatic logic [15:0] enc_f(input logic [7:0] b);
        return {b * 8'd3 + 8'd1, b ^ 8'hA5};
    endfunction

    // Stand-in encoders with latency 1 and 3
    logic [15:0] pipe_a;
    logic [15:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a    <= en_a ? enc_f(din_a) : 16'h0;
        pipe_b[0] <= en_b ? enc_f(din_b) : 16'h0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign dout_a = pipe_a;
    assign dout_b = pipe_b[2];

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    longint      cyc = 0;
    logic [7:0]  src0 [$];
    logic [7:0]  src1 [$];
    exp_t        sbq_a [$];
    exp_t        sbq_b [$];
    int          gap0 = 0;
    int          gap1 = 0;

    // Reference model state: owner -1 means nobody holds the encoder
    int          owner = -1;
    bit          last_ch = 1'b1;
    int          run_len = 0;
    bit          exp_en = 1'b0;
    logic [7:0]  exp_din = '0;
    longint      last_acc = -100;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Driver: present the head of each source queue
    always @(posedge clk) begin
        #1;
        if (gap0 > 0) begin
            ch0_valid = 1'b0;
            gap0--;
        end else begin
            ch0_valid = (src0.size() > 0);
        end
        ch0_data = (src0.size() > 0) ? src0[0] : 8'($urandom);
        if (gap1 > 0) begin
            ch1_valid = 1'b0;
            gap1--;
        end else begin
            ch1_valid = (src1.size() > 0);
        end
        ch1_data = (src1.size() > 0) ? src1[0] : 8'($urandom);
    end

    // Model: decides who is served at each edge and predicts results
    always @(posedge clk) begin
        bit         v [2];
        bit         n;
        logic [7:0] b;
        exp_t       e;
        cyc++;
        if (!rst) begin
            owner = -1; last_ch = 1'b1; run_len = 0;
            exp_en = 1'b0; exp_din = '0; last_acc = -100;
            src0.delete(); src1.delete(); sbq_a.delete(); sbq_b.delete();
        end else begin
            v[0] = ch0_valid;
            v[1] = ch1_valid;
            exp_en = 1'b0;
            if (owner < 0) begin
                run_len = 0;
                if (v[0] && v[1]) owner = last_ch ? 0 : 1;
                else if (v[0]) owner = 0;
                else if (v[1]) owner = 1;
            end else begin
                n = owner[0];
                if (!v[n]) begin
                    run_len = 0;
                    owner = v[!n] ? int'(!n) : -1;
                end else begin
                    b = n ? ch1_data : ch0_data;
                    if (n) void'(src1.pop_front()); else void'(src0.pop_front());
                    exp_en = 1'b1; exp_din = b; last_ch = n; last_acc = cyc;
                    e.ch = n; e.word = enc_f(b);
                    e.due = cyc + 1 + LAT_A; sbq_a.push_back(e);
                    e.due = cyc + 1 + LAT_B; sbq_b.push_back(e);
                    if (run_len == BURST - 1) begin
                        run_len = 0;
                        if (v[!n]) owner = int'(!n);
                    end else begin
                        run_len++;
                    end
                end
            end
        end
    end

    // Monitor: mid-cycle comparison of grants, encoder drive and results
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            chk("a_ready0", rdy0_a, owner == 0);
            chk("a_ready1", rdy1_a, owner == 1);
            chk("b_ready0", rdy0_b, owner == 0);
            chk("b_ready1", rdy1_b, owner == 1);
            chk("a_enc_enable", en_a, exp_en);
            chk("b_enc_enable", en_b, exp_en);
            chk("a_enc_data_in", din_a, exp_din);
            chk("b_enc_data_in", din_b, exp_din);
            chk("a_busy", busy_a, (owner >= 0) || (cyc - last_acc <= LAT_A));
            chk("b_busy", busy_b, (owner >= 0) || (cyc - last_acc <= LAT_B));
            if (ov_a) begin
                if (sbq_a.size() == 0) begin
                    chk("a_spurious_out_valid", ov_a, 0);
                end else begin
                    e = sbq_a.pop_front();
                    chk("a_out_ch", och_a, e.ch);
                    chk("a_out_data", od_a, e.word);
                    chk("a_out_cycle", cyc, e.due);
                end
            end else if (sbq_a.size() > 0 && sbq_a[0].due <= cyc) begin
                void'(sbq_a.pop_front());
                chk("a_missing_out_valid", ov_a, 1);
            end
            if (ov_b) begin
                if (sbq_b.size() == 0) begin
                    chk("b_spurious_out_valid", ov_b, 0);
                end else begin
                    e = sbq_b.pop_front();
                    chk("b_out_ch", och_b, e.ch);
                    chk("b_out_data", od_b, e.word);
                    chk("b_out_cycle", cyc, e.due);
                end
            end else if (sbq_b.size() > 0 && sbq_b[0].due <= cyc) begin
                void'(sbq_b.pop_front());
                chk("b_missing_out_valid", ov_b, 1);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, {rdy0_a, rdy1_a, rdy0_b, rdy1_b}, 0);
        chk({tag, "_enc_enable"}, {en_a, en_b}, 0);
        chk({tag, "_enc_data_in"}, {din_a, din_b}, 0);
        chk({tag, "_out_valid"}, {ov_a, ov_b}, 0);
        chk({tag, "_out_ch"}, {och_a, och_b}, 0);
        chk({tag, "_out_data"}, {od_a, od_b}, 0);
        chk({tag, "_busy"}, {busy_a, busy_b}, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset(tag);
        rst = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (src0.size() == 0 && src1.size() == 0 && sbq_a.size() == 0 && sbq_b.size() == 0)
                return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout pending a=%0d b=%0d required=0", sbq_a.size(), sbq_b.size());
    endtask

    task automatic wait_src0(input int left);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (src0.size() <= left) return;
        end
        checks++;
        errors++;
        $display("FAIL src0_wait_timeout actual=%0d required=%0d", src0.size(), left);
    endtask

    initial begin
        logic [7:0] t1 [6];
        t1 = '{8'd0, 8'd10, 8'd50, 8'd100, 8'd150, 8'd200};
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check_reset("reset0");
        rst = 1'b1;

        // Single channel after reset release
        foreach (t1[i]) src0.push_back(t1[i]);
        wait_idle();

        // Contention from a fresh reset: channel 0 wins first
        do_reset("reset1");
        for (int i = 0; i < 10; i++) begin
            src0.push_back(8'(i));
            src1.push_back(8'(100 + i));
        end
        wait_idle();

        // Uncontested channel 1 runs past the burst limit
        for (int i = 0; i < 12; i++) src1.push_back(8'(20 + i));
        wait_idle();

        // Channel 0 drops valid for two cycles mid-stream
        for (int i = 0; i < 12; i++) src0.push_back(8'(40 + i));
        wait_src0(8);
        gap0 = 2;
        wait_idle();

        // Randomized traffic with random valid gaps
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (src0.size() < 3 && $urandom_range(0, 2) == 0) src0.push_back(8'($urandom));
            if (src1.size() < 3 && $urandom_range(0, 2) == 0) src1.push_back(8'($urandom));
            if ($urandom_range(0, 9) == 0) gap0 = $urandom_range(1, 3);
            if ($urandom_range(0, 9) == 0) gap1 = $urandom_range(1, 3);
        end
        wait_idle();

        // Reset while words are still in flight
        for (int i = 0; i < 8; i++) src0.push_back(8'(200 + i));
        wait_src0(5);
        do_reset("reset_mid");
        for (int i = 0; i < 5; i++) begin
            src0.push_back(8'(60 + i));
            src1.push_back(8'(160 + i));
        end
        wait_idle();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/huffman_enc_arbiter.md
# huffman_enc_arbiter

Round-robin scheduler that shares one `huffman_encoder` instance between two byte-stream requesters (channel 0 and channel 1). It accepts bytes over per-channel valid/ready handshakes and drives the encoder's `enable`/`data_in`. A tag pipeline matched to the encoder latency returns each 16-bit `data_out` word to the originating channel. It sits between the two input streams and the encoder, with the encoder as a sub-instance's neighbour at the same level.

## Interface
- `ENC_LAT`, default 1: cycles from the encoder sampling `enc_data_in` with `enc_enable`=1 to the matching `enc_data_out` being stable; range 1..8.
- `BURST`, default 4: maximum consecutive bytes granted to one channel while the other channel is requesting; range 1..15.

Ports:
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `ch0_valid`  in  1  channel 0 byte available.
- `ch0_data`  in  8  channel 0 byte.
- `ch0_ready`  out  1  channel 0 byte accepted this cycle when `ch0_valid`=1.
- `ch1_valid`, `ch1_data[7:0]`, `ch1_ready`: same as channel 0.
- `enc_enable`  out  1  drives encoder `enable`.
- `enc_data_in`  out  8  drives encoder `data_in`.
- `enc_data_out`  in  16  encoder `data_out`.
- `out_valid`  out  1  `out_data` holds one encoded word.
- `out_ch`  out  1  channel that owns `out_data`.
- `out_data`  out  16  encoded word.
- `busy`  out  1  state ≠ IDLE or any tag in flight.

## Operation
- **FSM states:** IDLE, GNT0, GNT1. `rr_last` (1 bit) records the last granted channel; it is 1 after reset, so channel 0 wins first.
- **IDLE:**
  - Only one channel valid: go to that channel's GNT.
  - Both valid: go to GNT of `!rr_last`.
  - The grant decision costs one bubble cycle; nothing is accepted in IDLE.
- **GNTn:**
  - `chn_ready` = 1 combinationally (state==GNTn). The other channel's ready is 0.
  - A transfer occurs on `chn_valid & chn_ready`.
  - `bcnt` (4 bits) counts transfers in the current grant and is cleared on entering any GNT.
- **Leaving GNTn** (evaluated each cycle):
  - `chn_valid`=0: go to GNT(other) if the other channel is valid, else IDLE. No transfer occurs.
  - Transfer with `bcnt`==BURST-1: go to GNT(other) if the other channel is valid. Otherwise stay in GNTn with `bcnt` cleared, since an uncontested channel is never throttled.
  - Otherwise: stay, and `bcnt` increments on a transfer.
  - `rr_last` := n on every transfer.
- **Direct switches:** GNT0↔GNT1 transitions have no bubble.
- **Encoder drive (registered):** on a transfer at edge k, `enc_enable`=1 and `enc_data_in`=byte during cycle k+1. With no transfer, `enc_enable`=0 and `enc_data_in` holds its last value.
- **Tag pipeline:** a shift register of depth ENC_LAT+1 carrying {valid, ch}, loaded with {transfer, n} at each edge.
  - `out_valid`/`out_ch` come from the last stage.
  - `out_data` is `enc_data_out` registered on the edge where the last stage becomes valid.
  - `out_data` holds its value when `out_valid`=0.
- **No backpressure on outputs:** consumers must accept one word per cycle.

## Timing
- **Reset values** (`rst`=0 at an edge): state IDLE, `rr_last`=1, `bcnt`=0, all tags invalid.
  - Outputs: `ch0_ready`=0, `ch1_ready`=0, `enc_enable`=0, `enc_data_in`=0, `out_valid`=0, `out_ch`=0, `out_data`=0, `busy`=0.
- **Reset mid-stream:** in-flight tags are discarded and no `out_valid` pulse follows. Bytes accepted before reset are lost.
- **Latency:** a byte accepted at edge k appears with `out_valid`=1 during cycle k+2+ENC_LAT.
- **Throughput:** one byte per cycle sustained while a grant is held. Back-to-back channel switches keep one byte per cycle.
- **Simultaneous events:**
  - Both channels first valid in the same IDLE cycle: the round-robin pointer decides.
  - Valid dropping on the last burst beat has no effect, since that beat is the transfer.
- **Data stability:** `chn_data` is sampled only on a transfer edge. Its value while not ready is don't-care.

## Test plan
- **Single channel, reset release:** `ch0_valid` held, bytes 0,10,50,100,150,200 (ENC_LAT=1). Required:
  - `ch0_ready` rises one cycle after valid.
  - `enc_enable` is high for 6 consecutive cycles with `enc_data_in` in that order.
  - 6 `out_valid` pulses with `out_ch`=0, each word equal to the encoder output for that byte, first pulse 3 cycles after the first accept.
- **Contention, BURST=4:** both channels valid continuously, ch0 bytes 0..9, ch1 bytes 100..109. Required:
  - Accept order: ch0×4, ch1×4, ch0×4, ch1×4, …, with no idle cycle between grants.
  - `out_ch` sequence matches the accept order.
- **Uncontested burst limit:** only ch1 valid for 12 bytes. Required: 12 consecutive transfers with no gap; `bcnt` wraps without leaving GNT1.
- **Valid gap:** ch0 drops valid for 2 cycles mid-stream while ch1 idles. Required:
  - FSM goes to IDLE.
  - One bubble cycle after valid returns, then accepts resume.
  - `enc_enable`=0 during the gap.
- **Reset mid-operation:** assert `rst`=0 for 2 cycles while 2 words are in flight. Required:
  - No `out_valid` after reset.
  - All outputs at reset values.
  - After release, ch0 is granted first.
- **ENC_LAT=3 variant:** repeat the contention test. Required: every output arrives 5 cycles after its accept, with the correct `out_ch`.
